// File: rtl/bra_his_tab_gen_pkg.sv
// Shared defaults and flush FSM encoding for the local branch history table.
package bra_his_tab_gen_pkg;

  localparam int                    BHT_HIST_W   = 10;
  localparam int                    BHT_ENTRIES  = 256;
  localparam logic [BHT_HIST_W-1:0] BHT_INIT_VAL = '0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } flush_st_e;

endpackage

// File: rtl/bra_his_tab_gen_if.sv
// Lookup / update / repair / flush bundle of the branch history table.
interface bra_his_tab_gen_if #(
  parameter int HIST_W  = 10,
  parameter int ENTRIES = 256
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic              rd_en;
  logic [IDX_W-1:0]  rd_addr;
  logic              rd_vld;
  logic [HIST_W-1:0] rd_hist;
  logic              upd_en;
  logic [IDX_W-1:0]  upd_addr;
  logic              upd_taken;
  logic              rep_en;
  logic [IDX_W-1:0]  rep_addr;
  logic [HIST_W-1:0] rep_hist;
  logic              flush_req;
  logic              flush_busy;

  modport master (
    output rd_en, rd_addr, upd_en, upd_addr, upd_taken,
           rep_en, rep_addr, rep_hist, flush_req,
    input  rd_vld, rd_hist, flush_busy
  );

  modport slave (
    input  rd_en, rd_addr, upd_en, upd_addr, upd_taken,
           rep_en, rep_addr, rep_hist, flush_req,
    output rd_vld, rd_hist, flush_busy
  );
endinterface

// File: rtl/bra_his_tab_gen_bht_flush_seq.sv
// Background table clear: walks ptr over every entry once, one entry per cycle.
module bht_flush_seq
  import bra_his_tab_gen_pkg::*;
#(
  parameter int ENTRIES = BHT_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             clr_en,
  output logic [IDX_W-1:0] clr_addr
);

  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(ENTRIES - 1);
  localparam logic [IDX_W:0] ONE  = (IDX_W+1)'(1);

  flush_st_e      st;
  logic [IDX_W:0] ptr;

  // flush_req during a sweep is ignored: only IDLE looks at it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= ST_IDLE;
      ptr        <= '0;
      flush_busy <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (flush_req) begin
            st         <= ST_SWEEP;
            ptr        <= '0;
            flush_busy <= 1'b1;
          end
        end
        ST_SWEEP: begin
          ptr <= ptr + ONE;
          if (ptr == LAST) begin
            st         <= ST_IDLE;
            flush_busy <= 1'b0;
          end
        end
        default: begin
          st         <= ST_IDLE;
          flush_busy <= 1'b0;
        end
      endcase
    end
  end

  assign clr_en   = flush_busy;
  assign clr_addr = ptr[IDX_W-1:0];

endmodule

// File: rtl/bra_his_tab_gen.sv
// Local branch history table: registered lookup with write bypass,
// speculative shift update, mispredict repair and sequenced flush.
module bra_his_tab_gen
  import bra_his_tab_gen_pkg::*;
#(
  parameter int                HIST_W   = BHT_HIST_W,
  parameter int                ENTRIES  = BHT_ENTRIES,
  parameter logic [HIST_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  bra_his_tab_gen_if.slave  bus
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0][HIST_W-1:0] tab;
  logic                           clr_en;
  logic [IDX_W-1:0]               clr_addr;
  logic                           blk, rep_we, upd_we;
  logic [HIST_W-1:0]              upd_val, rd_val;

  bht_flush_seq #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_flush (
    .clk        (clk),
    .reset      (reset),
    .flush_req  (bus.flush_req),
    .flush_busy (bus.flush_busy),
    .clr_en     (clr_en),
    .clr_addr   (clr_addr)
  );

  // Writes are dropped while sweeping and in the cycle a flush is requested
  always_comb begin
    blk     = clr_en | bus.flush_req;
    rep_we  = bus.rep_en & ~blk;
    upd_we  = bus.upd_en & ~blk & ~(rep_we && (bus.rep_addr == bus.upd_addr));
    upd_val = {tab[bus.upd_addr][HIST_W-2:0], bus.upd_taken};
    rd_val  = tab[bus.rd_addr];
    if (clr_en)
      rd_val = INIT_VAL;
    else if (rep_we && (bus.rep_addr == bus.rd_addr))
      rd_val = bus.rep_hist;
    else if (upd_we && (bus.upd_addr == bus.rd_addr))
      rd_val = upd_val;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) tab[i] <= INIT_VAL;
    end else if (clr_en) begin
      tab[clr_addr] <= INIT_VAL;
    end else begin
      if (upd_we) tab[bus.upd_addr] <= upd_val;
      if (rep_we) tab[bus.rep_addr] <= bus.rep_hist;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rd_vld  <= 1'b0;
      bus.rd_hist <= INIT_VAL;
    end else begin
      bus.rd_vld <= bus.rd_en;
      if (bus.rd_en) bus.rd_hist <= rd_val;
    end
  end

endmodule

// File: tb/tb_bra_his_tab_gen.sv
// Directed bench for bra_his_tab_gen; expected lookups go through a scoreboard queue.
module tb_bra_his_tab_gen;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bra_his_tab_gen_if #(.HIST_W(10), .ENTRIES(256)) bus ();

  bra_his_tab_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_chk  = 0;
  int         n_fail = 0;
  int         cnt;
  logic [9:0] exp_q[$];
  bit         pend   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    bus.upd_en    = 1'b0;
    bus.upd_addr  = '0;
    bus.upd_taken = 1'b0;
    bus.rep_en    = 1'b0;
    bus.rep_addr  = '0;
    bus.rep_hist  = '0;
    bus.flush_req = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [9:0] e);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    exp_q.push_back(e);
    pend = 1'b1;
  endtask

  task automatic upd(input logic [7:0] a, input logic t);
    bus.upd_en    = 1'b1;
    bus.upd_addr  = a;
    bus.upd_taken = t;
  endtask

  task automatic rep(input logic [7:0] a, input logic [9:0] h);
    bus.rep_en   = 1'b1;
    bus.rep_addr = a;
    bus.rep_hist = h;
  endtask

  // Clock the staged inputs in, then check the lookup issued last cycle
  task automatic cycle();
    logic [9:0] e;
    @(posedge clk);
    #1;
    chk("rd_vld", 32'(bus.rd_vld), 32'(pend));
    if (pend) begin
      e = exp_q.pop_front();
      chk("rd_hist", 32'(bus.rd_hist), 32'(e));
    end
    pend = 1'b0;
    idle_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_in();
    #3;
    chk("reset_rd_vld", 32'(bus.rd_vld), 32'd0);
    chk("reset_rd_hist", 32'(bus.rd_hist), 32'd0);
    chk("reset_busy", 32'(bus.flush_busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    rd(5, 10'h000); cycle();

    // shift sequence 1,0,1,1 into entry 3
    upd(3, 1'b1); cycle();
    upd(3, 1'b0); cycle();
    upd(3, 1'b1); cycle();
    upd(3, 1'b1); cycle();
    rd(3, 10'h00B); cycle();

    for (int i = 0; i < 11; i++) begin
      upd(4, 1'b1); cycle();
    end
    rd(4, 10'h3FF); cycle();

    // update bypass: 0x00B shifted with 0 -> 0x016
    upd(3, 1'b0); rd(3, 10'h016); cycle();
    rd(3, 10'h016); cycle();

    // repair beats update on the same address, bypassed to the read
    rep(7, 10'h155); upd(7, 1'b1); rd(7, 10'h155); cycle();
    rd(7, 10'h155); cycle();

    // independent update and repair in one cycle
    upd(1, 1'b1); rep(2, 10'h2AA); rd(1, 10'h001); cycle();
    rd(2, 10'h2AA); cycle();
    rd(1, 10'h001); cycle();

    // flush
    rep(0, 10'h3C3); cycle();
    rep(128, 10'h0A5); cycle();
    rep(255, 10'h1FF); cycle();
    rep(9, 10'h0F0); cycle();
    rd(128, 10'h0A5); cycle();
    bus.flush_req = 1'b1; rep(9, 10'h111); rd(9, 10'h0F0); cycle();
    chk("flush_start_busy", 32'(bus.flush_busy), 32'd1);
    cnt = 0;
    while (bus.flush_busy && cnt < 600) begin
      cnt++;
      if (cnt == 20)  rd(255, 10'h000);
      if (cnt == 60)  bus.flush_req = 1'b1;
      if (cnt == 100) upd(0, 1'b1);
      if (cnt == 150) rep(5, 10'h3AA);
      cycle();
    end
    chk("flush_busy_cycles", 32'(cnt), 32'd256);
    rd(0, 10'h000);   cycle();
    rd(5, 10'h000);   cycle();
    rd(128, 10'h000); cycle();
    rd(255, 10'h000); cycle();
    rd(9, 10'h000);   cycle();
    cycle();
    chk("post_flush_busy", 32'(bus.flush_busy), 32'd0);

    // async reset in the middle of a sweep
    rep(50, 10'h2AA);  cycle();
    rep(200, 10'h155); cycle();
    bus.flush_req = 1'b1; cycle();
    repeat (39) cycle();
    bus.rd_en = 1'b1; bus.rd_addr = 8'd50;
    @(posedge clk);
    #2;
    chk("mid_sweep_rd_vld", 32'(bus.rd_vld), 32'd1);
    chk("mid_sweep_rd_hist", 32'(bus.rd_hist), 32'd0);
    chk("mid_sweep_busy", 32'(bus.flush_busy), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.flush_busy), 32'd0);
    chk("arst_rd_vld", 32'(bus.rd_vld), 32'd0);
    chk("arst_rd_hist", 32'(bus.rd_hist), 32'd0);
    idle_in();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    pend  = 1'b0;
    cycle();
    chk("post_arst_busy", 32'(bus.flush_busy), 32'd0);
    rd(50, 10'h000);  cycle();
    rd(200, 10'h000); cycle();
    rd(7, 10'h000);   cycle();
    cycle();
    chk("post_arst_idle", 32'(bus.flush_busy), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
